// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: immediate-format selector encodings and XLEN.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  // Format selector carried on tipo; 3'b101..3'b111 are illegal.
  typedef enum logic [2:0] {
    TIPO_I = 3'b000,
    TIPO_S = 3'b001,
    TIPO_B = 3'b010,
    TIPO_U = 3'b011,
    TIPO_J = 3'b100
  } tipo_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational RV32I immediate extraction and sign extension.
// Pure bit selection/concatenation, so bits outside the selected field
// never reach the output.
module imm_extract
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  input  logic [2:0]      tipo,
  output logic [XLEN-1:0] imm
);

  logic       s;
  logic [6:0] unused_opcode;

  assign s             = inst[31];
  assign unused_opcode = inst[6:0];

  // Format mux: reassemble the selected field, illegal selectors give zero.
  always_comb begin
    imm = '0;
    case (tipo)
      TIPO_I:  imm = {{20{s}}, inst[31:20]};
      TIPO_S:  imm = {{20{s}}, inst[31:25], inst[11:7]};
      TIPO_B:  imm = {{19{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      TIPO_U:  imm = {inst[31:12], 12'b0};
      TIPO_J:  imm = {{11{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/valor_inmediato.sv
// Registered immediate-value generator for the RV32I decode stage.
// One cycle of latency, one result per cycle, no backpressure.
// Optional feature macro: VALOR_INMEDIATO_TIPO_ERR_EN adds the tipo_err
// output flagging an illegal captured format selector.
module valor_inmediato
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst,
  input  logic [2:0]      tipo,
  input  logic            valid_in,
  output logic [XLEN-1:0] inmediato,
`ifdef VALOR_INMEDIATO_TIPO_ERR_EN
  output logic            tipo_err,
`endif
  output logic            valid_out
);

  logic [XLEN-1:0] imm_next;

  imm_extract u_imm_extract (
    .inst (inst),
    .tipo (tipo),
    .imm  (imm_next)
  );

  // Output register: capture on valid_in, hold otherwise; valid_out is a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inmediato <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        inmediato <= imm_next;
      end
    end
  end

`ifdef VALOR_INMEDIATO_TIPO_ERR_EN
  // Illegal-selector flag, captured alongside the immediate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tipo_err <= 1'b0;
    end else if (valid_in) begin
      tipo_err <= (tipo > TIPO_J);
    end
  end
`endif

endmodule

// File: tb/tb_valor_inmediato.sv
// Scoreboard bench for valor_inmediato: directed vectors with hand-computed
// immediates; unused instruction bits are filled with random noise.
module tb_valor_inmediato;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic [2:0]  tipo;
  logic        valid_in;
  logic [31:0] inmediato;
  logic        valid_out;
`ifdef VALOR_INMEDIATO_TIPO_ERR_EN
  logic        tipo_err;
`endif

  typedef struct packed {
    logic [31:0] imm;
    logic        err;
    logic [7:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  logic [31:0] last_imm = '0;
  logic        last_err = 1'b0;
  logic        stim_done = 1'b0;

  valor_inmediato dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst      (inst),
    .tipo      (tipo),
    .valid_in  (valid_in),
    .inmediato (inmediato),
`ifdef VALOR_INMEDIATO_TIPO_ERR_EN
    .tipo_err  (tipo_err),
`endif
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one valid transaction at the falling edge and queue its expectation.
  task automatic issue(input logic [2:0] t, input logic [31:0] i,
                       input logic [31:0] e, input logic [7:0] tag);
    exp_t x;
    @(negedge clk);
    tipo     = t;
    inst     = i;
    valid_in = 1'b1;
    x.imm = e;
    x.err = (t > 3'b100);
    x.tag = tag;
    exp_q.push_back(x);
    last_imm = e;
    last_err = x.err;
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    inst     = $urandom;
    tipo     = 3'($urandom);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every fresh result must match the oldest queued expectation.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got valid_out=1 inmediato=%h, expected no result", inmediato);
      end else begin
        x = exp_q.pop_front();
        check($sformatf("imm_vec%0d", x.tag), inmediato, x.imm);
`ifdef VALOR_INMEDIATO_TIPO_ERR_EN
        check($sformatf("tipo_err_vec%0d", x.tag), {31'b0, tipo_err}, {31'b0, x.err});
`endif
      end
    end
  end

  // Watchdog keeps the run bounded.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rst_n    = 1'b0;
    valid_in = 1'b1;
    inst     = 32'hFFFF_FFFF;
    tipo     = 3'b000;
    @(posedge clk); #1;
    check("reset_imm", inmediato, 32'h0);
    check("reset_valid", {31'b0, valid_out}, 32'h0);
`ifdef VALOR_INMEDIATO_TIPO_ERR_EN
    check("reset_err", {31'b0, tipo_err}, 32'h0);
`endif
    @(negedge clk);
    rst_n    = 1'b1;
    valid_in = 1'b0;

    // I format
    r = $urandom; r[31:20] = 12'h7D0; issue(3'b000, r, 32'd2000, 1);
    r = $urandom; r[31:20] = 12'h830; issue(3'b000, r, 32'hFFFF_F830, 2);
    // S format: 2000 -> imm[11:5]=0x3E imm[4:0]=0x10; -2000 -> 0x41 / 0x10
    r = $urandom; r[31:25] = 7'h3E; r[11:7] = 5'h10; issue(3'b001, r, 32'd2000, 3);
    r = $urandom; r[31:25] = 7'h41; r[11:7] = 5'h10; issue(3'b001, r, 32'hFFFF_F830, 4);
    // B format: 3000 and -3000
    r = $urandom; r[31] = 1'b0; r[7] = 1'b1; r[30:25] = 6'b011101; r[11:8] = 4'b1100;
    issue(3'b010, r, 32'h0000_0BB8, 5);
    r = $urandom; r[31] = 1'b1; r[7] = 1'b0; r[30:25] = 6'b100010; r[11:8] = 4'b0100;
    issue(3'b010, r, 32'hFFFF_F448, 6);
    // U format
    r = $urandom; r[31:12] = 20'h00064; issue(3'b011, r, 32'h0006_4000, 7);
    r = $urandom; r[31:12] = 20'hFFF9C; issue(3'b011, r, 32'hFFF9_C000, 8);
    // J format: 1000000 and -1000000
    r = $urandom; r[31] = 1'b0; r[30:21] = 10'b0100100000; r[20] = 1'b0; r[19:12] = 8'hF4;
    issue(3'b100, r, 32'h000F_4240, 9);
    r = $urandom; r[31] = 1'b1; r[30:21] = 10'b1011100000; r[20] = 1'b1; r[19:12] = 8'h0B;
    issue(3'b100, r, 32'hFFF0_BDC0, 10);
    // Illegal selectors
    issue(3'b111, 32'hFFFF_FFFF, 32'h0, 11);
    issue(3'b101, 32'h8000_0000, 32'h0, 12);
    r = $urandom; r[31:20] = 12'hABC; issue(3'b000, r, 32'hFFFF_FABC, 13);

    // Hold: inputs change while valid_in is low; outputs must not move.
    idle();
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    check("hold_imm", inmediato, last_imm);
    check("hold_valid", {31'b0, valid_out}, 32'h0);
`ifdef VALOR_INMEDIATO_TIPO_ERR_EN
    check("hold_err", {31'b0, tipo_err}, {31'b0, last_err});
`endif

    // Illegal capture then hold, to see tipo_err persist.
    issue(3'b110, 32'h1234_5678, 32'h0, 14);
    idle();
    @(posedge clk); #1;
    check("hold_after_illegal", inmediato, 32'h0);

    // Reset mid-stream: valid_in high in the same cycle, reset wins.
    r = $urandom; r[31:12] = 20'h12345; issue(3'b011, r, 32'h1234_5000, 15);
    @(negedge clk);
    r = $urandom; r[31:20] = 12'h555;
    inst  = r;
    tipo  = 3'b000;
    rst_n = 1'b0;
    valid_in = 1'b1;
    @(posedge clk); #1;
    check("midreset_imm", inmediato, 32'h0);
    check("midreset_valid", {31'b0, valid_out}, 32'h0);
`ifdef VALOR_INMEDIATO_TIPO_ERR_EN
    check("midreset_err", {31'b0, tipo_err}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    valid_in = 1'b0;
    r = $urandom; r[31:25] = 7'h00; r[11:7] = 5'h1F; issue(3'b001, r, 32'd31, 16);
    idle();
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'h0);
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
